// File: rtl/key_speed_sel.sv
// Push-button front end for the divider speed selector: two-flop synchronise,
// per-bit debounce, rising-edge press detect and a held one-hot selection.
module key_speed_sel #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [3:0]  DEFAULT_SEL     = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [3:0] key_sel,
  output logic       sel_changed,
  output logic [3:0] key_stable
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_stable;
  logic [3:0]    r_stable_d;
  logic [3:0]    r_sel;
  logic          r_changed;
  logic [CW-1:0] r_cnt [4];

  logic [3:0]    w_press;
  logic [3:0]    w_cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= key_in;
      r_s2 <= r_s1;
    end
  end

  // The counter only reaches CNT_LAST after an unbroken run of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  // Lowest-index press wins; the rest of the same cycle is discarded.
  always_comb begin
    w_cand = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_press[i] && (w_cand == '0)) w_cand[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable_d <= '0;
      r_sel      <= DEFAULT_SEL;
      r_changed  <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_changed  <= 1'b0;
      if ((w_press != '0) && (w_cand != r_sel)) begin
        r_sel     <= w_cand;
        r_changed <= 1'b1;
      end
    end
  end

  assign key_sel     = r_sel;
  assign sel_changed = r_changed;
  assign key_stable  = r_stable;

endmodule

// File: tb/tb_key_speed_sel.sv
// Directed bench for key_speed_sel with DEBOUNCE_CYCLES=4; expected edges are hand-derived.
module tb_key_speed_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_in = '0;
  logic [3:0] key_sel;
  logic       sel_changed;
  logic [3:0] key_stable;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  key_speed_sel #(
    .DEBOUNCE_CYCLES(4),
    .DEFAULT_SEL    (4'b0001)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_sel    (key_sel),
    .sel_changed(sel_changed),
    .key_stable (key_stable)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_in = '0;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    key_in = 4'b1111;
    rst    = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      if (e == 4) rst = 1'b0;
      tick();
      n_vec++;
      if (key_sel !== 4'b0001 || sel_changed !== 1'b0 || key_stable !== 4'b0000) begin
        $display("FAIL reset edge%0d: key_sel=%b sel_changed=%b key_stable=%b, required 0001/0/0000",
                 e, key_sel, sel_changed, key_stable);
        n_err++;
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_sel;
    do_reset();
    key_in = 4'b0010;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_sel = (e >= 7) ? 4'b0010 : 4'b0001;
      n_vec++;
      if (key_stable[1] !== (e >= 6) || key_sel !== exp_sel || sel_changed !== (e == 7)) begin
        $display("FAIL clean_press edge%0d: stable=%b sel=%b chg=%b, required stable1=%0d sel=%b chg=%0d",
                 e, key_stable, key_sel, sel_changed, (e >= 6), exp_sel, (e == 7));
        n_err++;
      end
    end
    key_in = 4'b0000;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_vec++;
      if (key_sel !== 4'b0010 || sel_changed !== 1'b0) begin
        $display("FAIL clean_release edge%0d: sel=%b chg=%b, required 0010/0", e, key_sel, sel_changed);
        n_err++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_sel;
    do_reset();
    for (int e = 0; e < 8; e++) begin
      key_in = ((e / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
      n_vec++;
      if (key_stable !== 4'b0000 || key_sel !== 4'b0001) begin
        $display("FAIL bounce_toggle step%0d: stable=%b sel=%b, required 0000/0001", e, key_stable, key_sel);
        n_err++;
      end
    end
    key_in = 4'b0100;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_sel = (e >= 7) ? 4'b0100 : 4'b0001;
      n_vec++;
      if (key_sel !== exp_sel || sel_changed !== (e == 7)) begin
        $display("FAIL bounce_hold edge%0d: sel=%b chg=%b, required %b/%0d", e, key_sel, sel_changed, exp_sel, (e == 7));
        n_err++;
      end
    end
  endtask

  task automatic test_priority();
    int pulses;
    do_reset();
    pulses = 0;
    key_in = 4'b1100;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (sel_changed === 1'b1) pulses++;
    end
    n_vec++;
    if (key_sel !== 4'b0100 || pulses != 1) begin
      $display("FAIL priority: sel=%b pulses=%0d, required 0100/1", key_sel, pulses);
      n_err++;
    end
    key_in = 4'b0000;
    for (int e = 1; e <= 10; e++) tick();
    pulses = 0;
    key_in = 4'b0100;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (sel_changed === 1'b1) pulses++;
    end
    n_vec++;
    if (key_sel !== 4'b0100 || pulses != 0) begin
      $display("FAIL same_select: sel=%b pulses=%0d, required 0100/0", key_sel, pulses);
      n_err++;
    end
  endtask

  task automatic test_sequence();
    int pulses;
    int bad_onehot;
    logic [3:0] k;
    do_reset();
    pulses = 0;
    bad_onehot = 0;
    for (int i = 0; i < 4; i++) begin
      k = 4'b0001 << i;
      key_in = k;
      for (int e = 0; e < 20; e++) begin
        if (e == 10) key_in = 4'b0000;
        tick();
        if (sel_changed === 1'b1) pulses++;
        if (!$onehot(key_sel)) bad_onehot++;
      end
      n_vec++;
      if (key_sel !== k) begin
        $display("FAIL sequence step%0d: sel=%b, required %b", i, key_sel, k);
        n_err++;
      end
    end
    n_vec++;
    if (pulses != 3 || bad_onehot != 0) begin
      $display("FAIL sequence_pulses: pulses=%0d non_onehot_cycles=%0d, required 3/0", pulses, bad_onehot);
      n_err++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [3:0] exp_sel;
    do_reset();
    key_in = 4'b1000;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (key_sel !== 4'b0001 || sel_changed !== 1'b0 || key_stable !== 4'b0000) begin
      $display("FAIL mid_debounce_reset: sel=%b chg=%b stable=%b, required 0001/0/0000", key_sel, sel_changed, key_stable);
      n_err++;
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_sel = (e >= 7) ? 4'b1000 : 4'b0001;
      n_vec++;
      if (key_sel !== exp_sel || sel_changed !== (e == 7)) begin
        $display("FAIL mid_debounce_after edge%0d: sel=%b chg=%b, required %b/%0d", e, key_sel, sel_changed, exp_sel, (e == 7));
        n_err++;
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    key_in = 4'b0010;
    for (int e = 1; e <= 7; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (key_sel !== 4'b0001 || sel_changed !== 1'b0 || key_stable !== 4'b0000) begin
      $display("FAIL mid_pulse_reset: sel=%b chg=%b stable=%b, required 0001/0/0000", key_sel, sel_changed, key_stable);
      n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_priority();
    test_sequence();
    test_reset_mid_debounce();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
